mw_adder_seq: RTL and testbench



---
 rtl/mw_adder_seq_if.sv | 41 ++++
 rtl/mw_adder_seq.sv | 135 +++++++++++++
 tb/tb_mw_adder_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mw_adder_seq_if.sv
// Handshake/operand bundle for mw_adder_seq: producer side (master) and adder side (slave).
// MW_ADDER_SEQ_SUB_EN adds the 'sub' request bit.
interface mw_adder_seq_if #(
    parameter int NBITS = 8,
    parameter int WORDS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WORDS*NBITS-1:0] a;
    logic [WORDS*NBITS-1:0] b;
    logic                   cin;
`ifdef MW_ADDER_SEQ_SUB_EN
    logic                   sub;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [WORDS*NBITS-1:0] sum;
    logic                   carry_out;
    logic                   overflow;
    logic                   busy;

`ifdef MW_ADDER_SEQ_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );
`endif
endinterface

// File: rtl/mw_adder_seq.sv
// Multi-word add sequencer: one shared NBITS-bit adder walks WORDS words LSW first.
// Define MW_ADDER_SEQ_SUB_EN to enable a-b via the 'sub' request bit.
module mw_adder_seq #(
    parameter int NBITS = 8,
    parameter int WORDS = 4,
    parameter int SIGND = 0
) (
    input  logic           clk,
    input  logic           rst,
    mw_adder_seq_if.slave  bus
);
    localparam int W    = WORDS * NBITS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
`ifdef MW_ADDER_SEQ_SUB_EN
    logic              sub_q, sub_d;
`endif

    int                base;
    logic [NBITS-1:0]  a_w, b_w, word_sum;
    logic              word_co;
    logic              ovf_word;

    // Shared word adder; b_q already holds the operand as fed (inverted for subtract).
    always_comb begin
        base               = NBITS * int'(idx_q);
        a_w                = a_q[base +: NBITS];
        b_w                = b_q[base +: NBITS];
        {word_co, word_sum} = {1'b0, a_w} + {1'b0, b_w} + {{NBITS{1'b0}}, carry_q};
        if (SIGND != 0) begin
            ovf_word = (~a_q[W-1] & ~b_q[W-1] &  word_sum[NBITS-1]) |
                       ( a_q[W-1] &  b_q[W-1] & ~word_sum[NBITS-1]);
        end else begin
`ifdef MW_ADDER_SEQ_SUB_EN
            ovf_word = word_co ^ sub_q;
`else
            ovf_word = word_co;
`endif
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch of the case can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
`ifdef MW_ADDER_SEQ_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef MW_ADDER_SEQ_SUB_EN
                    sub_d   = bus.sub;
                    if (bus.sub) begin
                        b_d     = ~bus.b;
                        carry_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                sum_d[base +: NBITS] = word_sum;
                carry_d              = word_co;
                idx_d                = idx_q + 1'b1;
                if (idx_q == IDXW'(WORDS - 1)) begin
                    carry_out_d = word_co;
                    overflow_d  = ovf_word;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef MW_ADDER_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge _d values together.
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
`ifdef MW_ADDER_SEQ_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    // in_ready is gated by rst so it reads 0 while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mw_adder_seq.sv
// Self-checking bench: unsigned (SIGND=0) and signed (SIGND=1) instances driven in lockstep,
// compared against an integer-arithmetic reference model.
module tb_mw_adder_seq;
    localparam int NBITS = 8;
    localparam int WORDS = 4;
    localparam int W     = NBITS * WORDS;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [W-1:0] exp_sum;
    logic         exp_co, exp_ovf_u, exp_ovf_s;

    mw_adder_seq_if #(.NBITS(NBITS), .WORDS(WORDS)) bus_u ();
    mw_adder_seq_if #(.NBITS(NBITS), .WORDS(WORDS)) bus_s ();

    mw_adder_seq #(.NBITS(NBITS), .WORDS(WORDS), .SIGND(0)) u_dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bus_u)
    );
    mw_adder_seq #(.NBITS(NBITS), .WORDS(WORDS), .SIGND(1)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        logic [W:0] full;
        longint     sres;
        longint     lim;
        lim = longint'(1) << (W - 1);
        if (sub) begin
            exp_sum   = a - b;
            exp_co    = (a >= b);
            exp_ovf_u = (a < b);
            sres      = longint'($signed(a)) - longint'($signed(b));
        end else begin
            full      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            exp_sum   = full[W-1:0];
            exp_co    = full[W];
            exp_ovf_u = full[W];
            sres      = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        exp_ovf_s = (sres >= lim) || (sres < -lim);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus_u.in_valid = v;  bus_s.in_valid = v;
        bus_u.a = a;         bus_s.a = a;
        bus_u.b = b;         bus_s.b = b;
        bus_u.cin = cin;     bus_s.cin = cin;
    endtask

    task automatic set_sub(input logic s);
`ifdef MW_ADDER_SEQ_SUB_EN
        bus_u.sub = s;
        bus_s.sub = s;
`else
        if (s) $display("note: subtract request ignored in add-only build");
`endif
    endtask

    task automatic set_ready(input logic r);
        bus_u.out_ready = r;
        bus_s.out_ready = r;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, input logic hold, input logic noise);
        int   waited;
        logic eff_sub;
        waited  = 0;
        eff_sub = sub;
`ifndef MW_ADDER_SEQ_SUB_EN
        eff_sub = 1'b0;
`endif
        model(a, b, cin, eff_sub);
        while (!bus_u.in_ready && waited < 20) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        check("in_ready_wait", bus_u.in_ready, 1'b1);
        drive(1'b1, a, b, cin);
        set_sub(eff_sub);
        set_ready(hold);
        @(posedge clk); @(negedge clk);
        if (noise) drive(1'b1, $urandom(), $urandom(), 1'($urandom()));
        else       drive(1'b0, a, b, cin);
        check("busy_run", bus_u.busy, 1'b1);
        check("in_ready_run", bus_u.in_ready, 1'b0);
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        while (!bus_u.out_valid && lat < 50) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        bus_u.in_valid = 1'b0;
        bus_s.in_valid = 1'b0;
        check("latency", lat, WORDS);
        check("out_valid_s", bus_s.out_valid, 1'b1);
        check("sum_u", bus_u.sum, exp_sum);
        check("carry_u", bus_u.carry_out, exp_co);
        check("ovf_u", bus_u.overflow, exp_ovf_u);
        check("sum_s", bus_s.sum, exp_sum);
        check("carry_s", bus_s.carry_out, exp_co);
        check("ovf_s", bus_s.overflow, exp_ovf_s);
    endtask

    task automatic release_out();
        set_ready(1'b1);
        @(posedge clk); @(negedge clk);
        set_ready(1'b0);
        check("drop_valid", bus_u.out_valid, 1'b0);
        check("idle_ready", bus_u.in_ready, 1'b1);
        check("idle_busy", bus_s.busy, 1'b0);
        check("sum_kept", bus_u.sum, exp_sum);
        check("ovf_kept", bus_s.overflow, exp_ovf_s);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic hold, input logic noise);
        start_op(a, b, cin, sub, hold, noise);
        wait_done();
        release_out();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready_u"}, bus_u.in_ready, 1'b0);
        check({tag, "_out_valid_u"}, bus_u.out_valid, 1'b0);
        check({tag, "_busy_u"}, bus_u.busy, 1'b0);
        check({tag, "_sum_u"}, bus_u.sum, '0);
        check({tag, "_carry_u"}, bus_u.carry_out, 1'b0);
        check({tag, "_ovf_u"}, bus_u.overflow, 1'b0);
        check({tag, "_sum_s"}, bus_s.sum, '0);
        check({tag, "_out_valid_s"}, bus_s.out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         seen;

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        set_sub(1'b0);
        set_ready(1'b0);
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_idle_ready", bus_u.in_ready, 1'b1);
        check("por_idle_busy", bus_u.busy, 1'b0);
        @(negedge clk);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef MW_ADDER_SEQ_SUB_EN
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Backpressure: new request waits in DONE, accepted right after the out handshake.
        start_op(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done();
        drive(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_in_ready", bus_u.in_ready, 1'b0);
            check("bp_out_valid", bus_u.out_valid, 1'b1);
            check("bp_sum", bus_u.sum, exp_sum);
            check("bp_carry", bus_u.carry_out, exp_co);
        end
        set_ready(1'b1);
        @(posedge clk); @(negedge clk);
        set_ready(1'b0);
        check("bp_idle_ready", bus_u.in_ready, 1'b1);
        check("bp_valid_drop", bus_u.out_valid, 1'b0);
        start_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done();
        release_out();

        // Asynchronous reset with idx at 2; the partial result must vanish.
        start_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_idle_ready", bus_u.in_ready, 1'b1);
        check("abort_idle_busy", bus_s.busy, 1'b0);
        seen = 1'b0;
        repeat (WORDS + 2) begin
            @(posedge clk);
            #1;
            if (bus_u.out_valid || bus_s.out_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 1'b0);
        @(negedge clk);
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 3))
                0:       rb = ~ra;
                1:       ra = 32'h7FFFFFFF;
                2:       rb = ra;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
